// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage: PC generation, credit-limited in-order memory
// requests, a small instruction buffer and redirect squashing of wrong-path work.
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [31:0]           imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [31:0]           out_inst,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]           DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         ONE_C    = CW'(1);
    localparam logic [PW-1:0]         LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    logic                  r_active;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop_cnt;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;

    logic [ADDR_WIDTH-1:0] w_buf_pc   [FIFO_DEPTH];
    logic [31:0]           w_buf_inst [FIFO_DEPTH];
    logic [CW:0]           w_inflight;
    logic                  w_credit;
    logic                  w_fire;
    logic                  w_resp_take;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [CW-1:0]         w_outstanding_next;
    logic [CW-1:0]         w_count_next;
    logic                  w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Credit covers both in-flight requests and buffered words, so the buffer can never overflow.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit       = (w_inflight < DEPTH_C);
    assign imem_req_valid = r_active && w_credit && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;

    assign w_fire        = imem_req_valid && imem_req_ready;
    assign w_resp_take   = imem_resp_valid && (r_outstanding != '0);
    assign w_push        = w_resp_take && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop         = out_valid && out_ready;
    assign w_redirect_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_fire && !w_resp_take) begin
            w_outstanding_next = r_outstanding + ONE_C;
        end else if (!w_fire && w_resp_take) begin
            w_outstanding_next = r_outstanding - ONE_C;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + ONE_C;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the wrong path.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop_cnt <= w_outstanding_next;
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_resp_take && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - ONE_C;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PC_STEP;
                    r_tail    <= ptr_inc(r_tail);
                end
                if (w_pop) begin
                    r_head <= ptr_inc(r_head);
                end
                r_count <= w_count_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ADDR_WIDTH-1:0] r_pc;
            logic [31:0]           r_inst;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_pc   <= '0;
                    r_inst <= '0;
                end else if (w_push && (r_tail == PW'(gi))) begin
                    r_pc   <= r_resp_pc;
                    r_inst <= imem_resp_data;
                end
            end

            assign w_buf_pc[gi]   = r_pc;
            assign w_buf_inst[gi] = r_inst;
        end
    endgenerate

    assign out_valid = (r_count != '0);
    assign out_pc    = w_buf_pc[r_head];
    assign out_inst  = w_buf_inst[r_head];
    assign opcode    = out_inst[6:0];
    assign rd        = out_inst[11:7];
    assign funct3    = out_inst[14:12];
    assign rs1       = out_inst[19:15];
    assign rs2       = out_inst[24:20];
    assign funct7    = out_inst[31:25];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a latency-configurable in-order memory model
// plus one task per scenario, each checking its own expectations inline.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        nreset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 1;
    int cyc     = 0;
    int acc_cnt = 0;
    int cons_cnt = 0;
    logic [31:0] exp_pc;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    inst_fetch #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0020_81B3;
            32'h4:   return 32'h4020_8033;
            32'h8:   return 32'h0000_0033;
            default: return {a[19:0], 12'h013};
        endcase
    endfunction

    // In-order memory: accepted requests answer mem_lat cycles later, one per cycle.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(cyc + mem_lat);
                acc_cnt++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0; mem_lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
        n_tests++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got pc %h inst %h expected 0 0", out_pc, out_inst); end
        n_tests++; if (opcode !== 7'h0 || rd !== 5'h0 || funct7 !== 7'h0) begin n_fail++; $display("FAIL reset_fields: got op %h rd %h f7 %h expected 0", opcode, rd, funct7); end
        tick();
        nreset = 1'b1;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_req_valid: got %b expected 0", imem_req_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got valid %b addr %h expected 1 0", imem_req_valid, imem_req_addr); end
        tick();
    endtask

    task automatic test_streaming();
        int got = 0;
        imem_req_ready = 1'b1; out_ready = 1'b1; exp_pc = 32'h0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++; if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stream_word: got pc %h inst %h expected pc %h inst %h", out_pc, out_inst, exp_pc, mem_word(exp_pc)); end
                if (got == 0) begin
                    n_tests++; if (opcode !== 7'b0110011 || funct3 !== 3'd0 || funct7 !== 7'd0) begin n_fail++; $display("FAIL stream_fields_op: got op %b f3 %0d f7 %b expected 0110011 0 0000000", opcode, funct3, funct7); end
                    n_tests++; if (rd !== 5'd3 || rs1 !== 5'd1 || rs2 !== 5'd2) begin n_fail++; $display("FAIL stream_fields_reg: got rd %0d rs1 %0d rs2 %0d expected 3 1 2", rd, rs1, rs2); end
                end
                if (got == 1) begin
                    n_tests++; if (funct7 !== 7'b0100000 || rd !== 5'd0) begin n_fail++; $display("FAIL stream_funct7: got f7 %b rd %0d expected 0100000 0", funct7, rd); end
                end
                got++; exp_pc += 4; cons_cnt++;
            end
            tick();
        end
        n_tests++; if (got != 3) begin n_fail++; $display("FAIL stream_timeout: got %0d words expected 3", got); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_tests++; if (acc_cnt - cons_cnt > 2) begin n_fail++; $display("FAIL bp_inflight: got %0d fetches in flight expected at most 2", acc_cnt - cons_cnt); end
            tick();
        end
        @(negedge clk); #1;
        n_tests++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got out_valid %b req_valid %b expected 1 0", out_valid, imem_req_valid); end
        n_tests++; if (acc_cnt - cons_cnt != 2) begin n_fail++; $display("FAIL bp_full: got %0d held expected 2", acc_cnt - cons_cnt); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++; if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL bp_resume: got pc %h inst %h expected pc %h inst %h", out_pc, out_inst, exp_pc, mem_word(exp_pc)); end
                got++; exp_pc += 4; cons_cnt++;
            end
            tick();
        end
        n_tests++; if (got != 2) begin n_fail++; $display("FAIL bp_timeout: got %0d words expected 2", got); end
    endtask

    // Stop fetching, consume whatever remains in order, and confirm the stage is idle at exp_pc.
    task automatic drain_and_check();
        imem_req_ready = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++; if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL drain_word: got pc %h inst %h expected pc %h inst %h", out_pc, out_inst, exp_pc, mem_word(exp_pc)); end
                exp_pc += 4;
            end
            tick();
        end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_fail++; $display("FAIL drain_idle: got out_valid %b req_valid %b addr %h expected 0 1 %h", out_valid, imem_req_valid, imem_req_addr, exp_pc); end
        tick();
    endtask

    task automatic test_redirect_inflight();
        bit seen = 0;
        mem_lat = 3; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_forced: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_out_valid: got %b expected 0", out_valid); end
        tick();
        tick();
        mem_lat = 1; imem_req_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_drop: got out_valid %b expected 0", out_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_first_req: got valid %b addr %h expected 1 00000100", imem_req_valid, imem_req_addr); end
        tick();
        @(negedge clk);
        n_tests++; if (imem_req_addr !== 32'h104) begin n_fail++; $display("FAIL redir_next_req: got %h expected 00000104", imem_req_addr); end
        tick();
        exp_pc = 32'h100;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++; if (out_pc !== 32'h100 || out_inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_target: got pc %h inst %h expected 00000100 %h", out_pc, out_inst, mem_word(32'h100)); end
                seen = 1; exp_pc += 4;
            end
            tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL redir_timeout: got no instruction expected pc 00000100"); end
        drain_and_check();
    endtask

    task automatic test_misaligned_redirect();
        bit seen = 0;
        out_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
        tick();
        tick();
        // A response lands in this cycle and the buffer already holds one word.
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_req_forced: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush: got out_valid %b expected 0", out_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL mis_req_addr: got valid %b addr %h expected 1 00000100", imem_req_valid, imem_req_addr); end
        tick();
        imem_req_ready = 1'b1; out_ready = 1'b1; exp_pc = 32'h100;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++; if (out_pc !== 32'h100 || out_inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL mis_target: got pc %h inst %h expected 00000100 %h", out_pc, out_inst, mem_word(32'h100)); end
                seen = 1; exp_pc += 4;
            end
            tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL mis_timeout: got no instruction expected pc 00000100"); end
        drain_and_check();
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        mem_lat = 4; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL arst_req: got valid %b addr %h expected 0 0", imem_req_valid, imem_req_addr); end
        n_tests++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin n_fail++; $display("FAIL arst_out: got valid %b pc %h inst %h expected 0 0 0", out_valid, out_pc, out_inst); end
        tick();
        nreset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_late_resp: got out_valid %b expected 0", out_valid); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL arst_first_req: got valid %b addr %h expected 1 0", imem_req_valid, imem_req_addr); end
        tick();
        mem_lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++; if (out_pc !== 32'h0 || out_inst !== 32'h0020_81B3) begin n_fail++; $display("FAIL arst_refetch: got pc %h inst %h expected 0 002081b3", out_pc, out_inst); end
                seen = 1;
            end
            tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL arst_timeout: got no instruction expected pc 0"); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        drain_and_check();
        test_redirect_inflight();
        test_misaligned_redirect();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
